// File: rtl/mode_mux.sv
// Four-requester byte multiplexer with selectable fixed-priority / round-robin arbitration.
// Build option MODE_MUX_HOLD_EN: data_out holds its last value on idle cycles instead of clearing.
module mode_mux (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       mode,
  output logic [3:0] grant,
  output logic [7:0] data_out
);

  logic [1:0] last;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic [7:0] pick_data;

  // Loops scan in reverse search order so the first match in search order is the last one written.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    if (!mode) begin
      for (int i = 3; i >= 0; i--) begin
        if (req[i]) begin
          pick  = 2'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 4; k >= 1; k--) begin
        idx = last + 2'(k);
        if (req[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_data = 8'h00;
    case (pick)
      2'd0: pick_data = data_in0;
      2'd1: pick_data = data_in1;
      2'd2: pick_data = data_in2;
      2'd3: pick_data = data_in3;
      default: pick_data = 8'h00;
    endcase
  end

  // last resets to 3 so the first round-robin search begins at requester 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant    <= 4'b0000;
      data_out <= 8'h00;
      last     <= 2'd3;
    end else if (found) begin
      grant    <= 4'b0001 << pick;
      data_out <= pick_data;
      last     <= pick;
    end else begin
      grant    <= 4'b0000;
`ifdef MODE_MUX_HOLD_EN
      data_out <= data_out;
`else
      data_out <= 8'h00;
`endif
    end
  end

endmodule

// File: tb/tb_mode_mux.sv
// Self-checking bench for mode_mux: directed scenarios plus randomized traffic
// compared against an index-arithmetic reference model.
module tb_mode_mux;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       mode;
  logic [3:0] grant;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

  // reference model state
  int         m_last;
  logic [3:0] exp_grant;
  logic [7:0] exp_data;

  mode_mux dut (
    .clk(clk), .rst(rst), .req(req),
    .data_in0(data_in0), .data_in1(data_in1),
    .data_in2(data_in2), .data_in3(data_in3),
    .mode(mode), .grant(grant), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] din(input int n);
    case (n)
      0: return data_in0;
      1: return data_in1;
      2: return data_in2;
      default: return data_in3;
    endcase
  endfunction

  // Model of what the next edge should produce, from the spec's search rules.
  task automatic model_edge();
    int winner;
    winner = -1;
    if (!rst) begin
      exp_grant = 4'b0000;
      exp_data  = 8'h00;
      m_last    = 3;
      return;
    end
    if (mode == 1'b0) begin
      for (int n = 0; n < 4 && winner < 0; n++)
        if (req[n]) winner = n;
    end else begin
      for (int k = 1; k <= 4 && winner < 0; k++)
        if (req[(m_last + k) % 4]) winner = (m_last + k) % 4;
    end
    if (winner >= 0) begin
      exp_grant = 4'(1 << winner);
      exp_data  = din(winner);
      m_last    = winner;
    end else begin
      exp_grant = 4'b0000;
`ifndef MODE_MUX_HOLD_EN
      exp_data  = 8'h00;
`endif
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abcd();
    data_in0 = 8'hA0; data_in1 = 8'hB1; data_in2 = 8'hC2; data_in3 = 8'hD3;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b0000; mode = 1'b0; set_abcd();
    step();
    checks++;
    if (grant !== 4'b0000 || data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset: grant=%b data_out=%h expected 0000/00", grant, data_out);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (grant !== 4'b0000 || data_out !== 8'h00) begin
        errors++;
        $display("[TB] FAIL idle_after_reset: grant=%b data_out=%h expected 0000/00", grant, data_out);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0] reqs [3] = '{4'b1101, 4'b0010, 4'b0000};
    logic [3:0] gnts [3] = '{4'b0001, 4'b0010, 4'b0000};
    logic [7:0] dats [3] = '{8'hA0, 8'hB1, 8'h00};
`ifdef MODE_MUX_HOLD_EN
    dats[2] = 8'hB1;
`endif
    mode = 1'b0;
    for (int t = 0; t < 3; t++) begin
      req = reqs[t];
      step();
      checks++;
      if (grant !== gnts[t] || data_out !== dats[t]) begin
        errors++;
        $display("[TB] FAIL fixed_priority[%0d]: grant=%b data_out=%h expected %b/%h",
                 t, grant, data_out, gnts[t], dats[t]);
      end
    end
  endtask

  task automatic test_round_robin_rotation();
    logic [3:0] gnts [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0] dats [4] = '{8'hC2, 8'hD3, 8'hA0, 8'hB1};
    mode = 1'b1; req = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      step();
      checks++;
      if (grant !== gnts[t] || data_out !== dats[t]) begin
        errors++;
        $display("[TB] FAIL rr_rotation[%0d]: grant=%b data_out=%h expected %b/%h",
                 t, grant, data_out, gnts[t], dats[t]);
      end
    end
  endtask

  task automatic test_round_robin_changing();
    logic [3:0] reqs [3] = '{4'b1010, 4'b0011, 4'b0100};
    logic [3:0] gnts [3] = '{4'b1000, 4'b0001, 4'b0100};
    logic [7:0] dats [3] = '{8'hD3, 8'hA0, 8'hC2};
    mode = 1'b1;
    for (int t = 0; t < 3; t++) begin
      req = reqs[t];
      step();
      checks++;
      if (grant !== gnts[t] || data_out !== dats[t]) begin
        errors++;
        $display("[TB] FAIL rr_changing[%0d]: grant=%b data_out=%h expected %b/%h",
                 t, grant, data_out, gnts[t], dats[t]);
      end
    end
    // only the last-granted requester asks again: it must win again
    req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || data_out !== 8'hC2) begin
      errors++;
      $display("[TB] FAIL rr_self_regrant: grant=%b data_out=%h expected 0100/c2", grant, data_out);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; req = 4'b1111; rst = 1'b0;
    step();
    checks++;
    if (grant !== 4'b0000 || data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid: grant=%b data_out=%h expected 0000/00", grant, data_out);
    end
    rst = 1'b1;
    step();
    checks++;
    if (grant !== 4'b0001 || data_out !== 8'hA0) begin
      errors++;
      $display("[TB] FAIL reset_pointer: grant=%b data_out=%h expected 0001/a0", grant, data_out);
    end
  endtask

  task automatic test_idle_data();
    logic [7:0] idle_val;
`ifdef MODE_MUX_HOLD_EN
    idle_val = 8'hC2;
`else
    idle_val = 8'h00;
`endif
    mode = 1'b0; req = 4'b0100;
    step();
    checks++;
    if (grant !== 4'b0100 || data_out !== 8'hC2) begin
      errors++;
      $display("[TB] FAIL idle_setup: grant=%b data_out=%h expected 0100/c2", grant, data_out);
    end
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (grant !== 4'b0000 || data_out !== idle_val) begin
        errors++;
        $display("[TB] FAIL idle_data[%0d]: grant=%b data_out=%h expected 0000/%h",
                 c, grant, data_out, idle_val);
      end
    end
  endtask

  task automatic test_data_registered();
    mode = 1'b0; req = 4'b0001; data_in0 = 8'h5A;
    step();
    data_in0 = 8'h33;
    #2;
    checks++;
    if (data_out !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL data_registered: data_out=%h expected 5a", data_out);
    end
    set_abcd();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 49) != 0);
      mode = 1'($urandom_range(0, 1));
      req  = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
      data_in0 = 8'($urandom); data_in1 = 8'($urandom);
      data_in2 = 8'($urandom); data_in3 = 8'($urandom);
      step();
      checks++;
      if (grant !== exp_grant || data_out !== exp_data) begin
        errors++;
        $display("[TB] FAIL random[%0d]: grant=%b data_out=%h expected %b/%h",
                 c, grant, data_out, exp_grant, exp_data);
      end
      checks++;
      if ($countones(grant) > 1) begin
        errors++;
        $display("[TB] FAIL onehot[%0d]: grant=%b expected at most one bit", c, grant);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    m_last = 3; exp_grant = 4'b0000; exp_data = 8'h00;
    rst = 1'b0; req = 4'b0000; mode = 1'b0; set_abcd();
    #2;
    test_reset();
    test_fixed_priority();
    test_round_robin_rotation();
    test_round_robin_changing();
    test_reset_mid();
    test_idle_data();
    test_data_registered();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_mux.md
# mode_mux

Four-input, 8-bit arbitrated data multiplexer with run-time selectable arbitration policy: fixed priority or round-robin. Each cycle it picks one requester, registers a one-hot grant and forwards that requester's data byte. It sits in front of a shared single-byte sink and serializes four producers onto it.

## Interface

No parameters. Width is fixed at 4 requesters × 8 bits.

- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-low reset. The block is reset when rst = 0 at a rising clk edge.
- req  input  4  request vector; bit i set means requester i wants the output.
- data_in0  input  8  data of requester 0.
- data_in1  input  8  data of requester 1.
- data_in2  input  8  data of requester 2.
- data_in3  input  8  data of requester 3.
- mode  input  1  arbitration policy: 0 = fixed priority, 1 = round-robin.
- grant  output  4  registered one-hot grant, or 0000 when nothing is granted.
- data_out  output  8  registered data of the granted requester.

## Operation

- Internal state:
  - `last` (2 bits): index of the most recently granted requester.
  - The grant and data_out registers.
- Fixed priority (mode = 0):
  - Grant the lowest set index in req; req[0] has the highest priority.
- Round-robin (mode = 1):
  - Search indices (last+1), (last+2), (last+3), (last+4), all mod 4.
  - Grant the first one whose req bit is set.
  - Wrap-around: 3 → 0.
  - If only the last-granted requester is requesting, it is granted again.
- Pointer update:
  - `last` loads the granted index on every cycle with a nonzero grant, in both modes.
  - With req = 0000, `last` is unchanged.
- Data path:
  - data_out loads the granted requester's data_inN, sampled at the same edge as the grant decision.
- No request (req = 0000):
  - grant = 0000.
  - data_out = 8'h00, unless MODE_MUX_HOLD_EN is defined (see Configuration).
- Grant is always one-hot or zero; two bits are never set at once.
- Mode may change on any cycle. The new policy applies at the next edge, using the current `last`; no flush is needed.

## Timing

- Reset:
  - rst = 0 at an edge sets grant = 0000, data_out = 8'h00 and last = 3, so the first round-robin search starts at index 0.
  - Reset has priority over everything else.
  - Asserting reset mid-stream discards the arbitration history.
- Latency is one cycle. req, mode and data_in* sampled at edge k are reflected on grant and data_out immediately after edge k. There is no combinational path from inputs to outputs.
- No handshake:
  - A grant lasts exactly one cycle.
  - A requester that holds req keeps competing every cycle.
  - Dropping req takes effect at the next edge.
- data_out is a registered copy. A data_inN change after the capturing edge does not affect data_out until the next edge.

## Configuration

- MODE_MUX_HOLD_EN defined: on a cycle with req = 0000, grant = 0000 and data_out keeps its previous value.
- MODE_MUX_HOLD_EN undefined (default): on a cycle with req = 0000, grant = 0000 and data_out = 8'h00.
- Reset behaviour is identical in both builds.

## Test plan

Data for all scenarios: data_in0..3 = A0, B1, C2, D3.

- Reset: hold rst = 0 for one edge → grant = 0000, data_out = 00; release rst → outputs stay 0000/00 while req = 0000.
- Fixed priority, mode = 0, one request pattern per edge:

  | req | grant | data_out |
  |---|---|---|
  | 1101 | 0001 | A0 |
  | 0010 | 0010 | B1 |
  | 0000 | 0000 | 00 (default build) |

- Round-robin rotation: continue from the fixed-priority scenario (last = 1), set mode = 1 and hold req = 1111 for four edges → grant 0100/C2, 1000/D3, 0001/A0, 0010/B1.
- Round-robin with changing requests: continue from the rotation scenario (last = 1), one pattern per edge:

  | req | grant | data_out |
  |---|---|---|
  | 1010 | 1000 | D3 |
  | 0011 | 0001 | A0 |
  | 0100 | 0100 | C2 |

- Reset mid-operation: in round-robin with last = 2, drive rst = 0 for one edge, release it, then apply req = 1111 → grant = 0001 (pointer back to 3); data_out = 00 during the reset cycle.
- Hold build (MODE_MUX_HOLD_EN defined): grant requester 2 (C2), then apply req = 0000 for two edges → grant = 0000, data_out stays C2.
